// File: rtl/mipi_frame_writer.sv
// Camera line/frame writer: turns a sync-framed pixel stream into addressed
// frame-buffer writes through a small first-word-fall-through write buffer.
module mipi_frame_writer #(
  parameter int H_PIXELS   = 960,
  parameter int V_LINES    = 540,
  parameter int ADDR_W     = 20,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              cam_clk_i,
  input  logic              reset_n_i,
  input  logic              vsync_i,
  input  logic              hsync_i,
  input  logic              pix_valid_i,
  input  logic [15:0]       pix_data_i,
  input  logic              line_end_i,
  input  logic              wr_ready_i,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [15:0]       wr_data_o,
  output logic              frame_start_o,
  output logic              frame_done_o,
  output logic [9:0]        line_cnt_o,
  output logic              overflow_o,
  output logic              busy_o
);

  localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W   = PTR_W + 1;
  localparam int PIX_W   = $clog2(H_PIXELS + 1);
  localparam int ENTRY_W = ADDR_W + 16;

  localparam logic [PIX_W-1:0]  H_LIM    = PIX_W'(H_PIXELS);
  localparam logic [ADDR_W-1:0] H_STEP   = ADDR_W'(H_PIXELS);
  localparam logic [9:0]        V_LIM    = 10'(V_LINES);
  localparam logic [CNT_W-1:0]  FIFO_MAX = CNT_W'(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_WAIT_LINE = 2'd1;
  localparam logic [1:0] S_ACTIVE    = 2'd2;
  localparam logic [1:0] S_FLUSH     = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [9:0]        line_cnt_q, line_cnt_d;
  logic [PIX_W-1:0]  pixcnt_q, pixcnt_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic              frame_start_q, frame_start_d;
  logic              overflow_q, overflow_d;

  logic vsync_q, hsync_q, line_end_q;
  logic vsync_rise, hsync_rise, line_end_rise;

  logic [ENTRY_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               fifo_empty, fifo_full;
  logic               push_req, push, pop;
  logic [ADDR_W-1:0]  push_addr;
  logic [ENTRY_W-1:0] head;

  // VSYNC history resets high so a level already present at reset release
  // cannot be mistaken for a new frame.
  always_ff @(posedge cam_clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      vsync_q    <= 1'b1;
      hsync_q    <= 1'b0;
      line_end_q <= 1'b0;
    end else begin
      vsync_q    <= vsync_i;
      hsync_q    <= hsync_i;
      line_end_q <= line_end_i;
    end
  end

  assign vsync_rise    = vsync_i & ~vsync_q;
  assign hsync_rise    = hsync_i & ~hsync_q;
  assign line_end_rise = line_end_i & ~line_end_q;

  assign push_addr = base_q + ADDR_W'(pixcnt_q);

  always_comb begin
    state_d       = state_q;
    line_cnt_d    = line_cnt_q;
    pixcnt_d      = pixcnt_q;
    base_d        = base_q;
    frame_start_d = 1'b0;
    push_req      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (vsync_rise) begin
          state_d       = S_WAIT_LINE;
          line_cnt_d    = '0;
          pixcnt_d      = '0;
          base_d        = '0;
          frame_start_d = 1'b1;
        end
      end
      S_WAIT_LINE: begin
        if (vsync_rise) begin
          state_d       = S_WAIT_LINE;
          line_cnt_d    = '0;
          pixcnt_d      = '0;
          base_d        = '0;
          frame_start_d = 1'b1;
        end else if (hsync_rise) begin
          state_d  = S_ACTIVE;
          pixcnt_d = '0;
        end
      end
      S_ACTIVE: begin
        // The pixel uses the current base even when the line closes this cycle.
        if (pix_valid_i && (pixcnt_q < H_LIM)) begin
          push_req = 1'b1;
          pixcnt_d = pixcnt_q + 1'b1;
        end
        if (line_end_rise) begin
          line_cnt_d = line_cnt_q + 10'd1;
          base_d     = base_q + H_STEP;
          state_d    = ((line_cnt_q + 10'd1) == V_LIM) ? S_FLUSH : S_WAIT_LINE;
        end
      end
      S_FLUSH: begin
        if (fifo_empty) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge cam_clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q       <= S_IDLE;
      line_cnt_q    <= '0;
      pixcnt_q      <= '0;
      base_q        <= '0;
      frame_start_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      line_cnt_q    <= line_cnt_d;
      pixcnt_q      <= pixcnt_d;
      base_q        <= base_d;
      frame_start_q <= frame_start_d;
      overflow_q    <= overflow_d;
    end
  end

  // A full buffer still accepts a pixel when the head leaves in the same cycle.
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == FIFO_MAX);
  assign pop        = ~fifo_empty & wr_ready_i;
  assign push       = push_req & (~fifo_full | pop);
  assign overflow_d = overflow_q | (push_req & fifo_full & ~pop);

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge cam_clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      count_q <= count_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge cam_clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {push_addr, pix_data_i};
    end
  end

  assign head = mem_q[rd_ptr_q];

  // Storage is not reset, so the head is masked to keep outputs at zero when empty.
  assign wr_en_o       = ~fifo_empty;
  assign wr_addr_o     = fifo_empty ? '0 : head[ENTRY_W-1:16];
  assign wr_data_o     = fifo_empty ? '0 : head[15:0];
  assign frame_start_o = frame_start_q;
  assign frame_done_o  = (state_q == S_FLUSH) & fifo_empty;
  assign line_cnt_o    = line_cnt_q;
  assign overflow_o    = overflow_q;
  assign busy_o        = (state_q != S_IDLE);

endmodule

// File: tb/tb_mipi_frame_writer.sv
// Randomized scoreboard bench for mipi_frame_writer: a frame-level reference
// model queues expected writes, a negedge monitor checks every DUT output.
module tb_mipi_frame_writer;

  localparam int H     = 4;
  localparam int V     = 2;
  localparam int AW    = 20;
  localparam int DEPTH = 4;

  localparam int M_IDLE   = 0;
  localparam int M_WAIT   = 1;
  localparam int M_ACTIVE = 2;
  localparam int M_FLUSH  = 3;

  typedef struct {
    logic [AW-1:0] addr;
    logic [15:0]   data;
  } entry_t;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          vsync, hsync, pix_valid, line_end, wr_ready;
  logic [15:0]   pix_data;
  logic          wr_en, frame_start, frame_done, overflow, busy;
  logic [AW-1:0] wr_addr;
  logic [15:0]   wr_data;
  logic [9:0]    line_cnt;

  int     testsRun    = 0;
  int     testsFailed = 0;
  bit     randReady   = 0;
  entry_t expQ[$];
  int     phase, line, pix;
  bit     mOverflow, expStart, prevV, prevH, prevL, poppedNow;

  mipi_frame_writer #(
    .H_PIXELS(H), .V_LINES(V), .ADDR_W(AW), .FIFO_DEPTH(DEPTH)
  ) dut (
    .cam_clk_i(clk), .reset_n_i(reset_n), .vsync_i(vsync), .hsync_i(hsync),
    .pix_valid_i(pix_valid), .pix_data_i(pix_data), .line_end_i(line_end),
    .wr_ready_i(wr_ready), .wr_en_o(wr_en), .wr_addr_o(wr_addr),
    .wr_data_o(wr_data), .frame_start_o(frame_start), .frame_done_o(frame_done),
    .line_cnt_o(line_cnt), .overflow_o(overflow), .busy_o(busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic modelStartFrame();
    phase    = M_WAIT;
    line     = 0;
    pix      = 0;
    expStart = 1;
  endtask

  // Reference model: frame rules on sync edges, address = line*H + pixel.
  always @(posedge clk or negedge reset_n) begin
    bit vRise, hRise, lRise;
    int occ;
    if (!reset_n) begin
      phase = M_IDLE; line = 0; pix = 0; mOverflow = 0; expStart = 0;
      prevV = 1; prevH = 0; prevL = 0; poppedNow = 0;
      expQ.delete();
    end else begin
      vRise = vsync && !prevV;
      hRise = hsync && !prevH;
      lRise = line_end && !prevL;
      prevV = vsync; prevH = hsync; prevL = line_end;
      occ = expQ.size() + int'(poppedNow);
      expStart = 0;
      case (phase)
        M_IDLE: if (vRise) modelStartFrame();
        M_WAIT: begin
          if (vRise) modelStartFrame();
          else if (hRise) begin phase = M_ACTIVE; pix = 0; end
        end
        M_ACTIVE: begin
          if (pix_valid && pix < H) begin
            if (occ < DEPTH || poppedNow) expQ.push_back('{addr: AW'(line * H + pix), data: pix_data});
            else mOverflow = 1;
            pix++;
          end
          if (lRise) begin
            line++;
            phase = (line == V) ? M_FLUSH : M_WAIT;
          end
        end
        default: if (occ == 0) phase = M_IDLE;
      endcase
    end
  end

  always @(negedge clk) begin
    if (reset_n) begin
      checkOutput("wr_en", wr_en, expQ.size() != 0);
      if (expQ.size() != 0) begin
        checkOutput("wr_addr", wr_addr, expQ[0].addr);
        checkOutput("wr_data", wr_data, expQ[0].data);
      end
      checkOutput("frame_done", frame_done, phase == M_FLUSH && expQ.size() == 0);
      checkOutput("frame_start", frame_start, expStart);
      checkOutput("line_cnt", line_cnt, line[9:0]);
      checkOutput("overflow", overflow, mOverflow);
      checkOutput("busy", busy, phase != M_IDLE);
      poppedNow = 0;
      if (expQ.size() != 0 && wr_ready) begin
        void'(expQ.pop_front());
        poppedNow = 1;
      end
    end
  end

  task automatic applyStimulus();
    @(posedge clk);
    #1;
    pix_valid = 1'b0;
    if (randReady) wr_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic startFrame();
    vsync = 1'b0; applyStimulus();
    vsync = 1'b1; applyStimulus();
  endtask

  task automatic startLine();
    hsync = 1'b0; line_end = 1'b0; applyStimulus();
    hsync = 1'b1; applyStimulus();
  endtask

  task automatic sendPixels(input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      pix_valid = 1'b1;
      pix_data  = 16'($urandom);
      applyStimulus();
      if (gaps) repeat ($urandom_range(0, 2)) applyStimulus();
    end
  endtask

  task automatic endLine(input bit withPixel);
    hsync = 1'b0;
    line_end = 1'b1;
    if (withPixel) begin
      pix_valid = 1'b1;
      pix_data  = 16'($urandom);
    end
    applyStimulus();
  endtask

  task automatic waitDrained(input int budget);
    int n = 0;
    while ((phase != M_IDLE || expQ.size() != 0) && n < budget) begin
      applyStimulus();
      n++;
    end
    checkOutput("drain_timeout", n < budget, 1);
  endtask

  initial begin
    reset_n = 1'b0; vsync = 1'b0; hsync = 1'b0; pix_valid = 1'b0;
    line_end = 1'b0; wr_ready = 1'b1; pix_data = '0;
    repeat (3) applyStimulus();
    checkOutput("rst_wr_en", wr_en, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_line_cnt", line_cnt, 0);
    checkOutput("rst_wr_addr", wr_addr, 0);
    reset_n = 1'b1;
    applyStimulus();

    // Basic frame, extra strobe beyond H ignored, pixel coincident with line end.
    startFrame();
    startLine(); sendPixels(H + 1, 0); endLine(0);
    checkOutput("line_cnt_after_line0", line_cnt, 1);
    startLine(); sendPixels(H - 1, 0); endLine(1);
    waitDrained(100);
    applyStimulus();
    checkOutput("idle_after_frame", busy, 0);

    // Stalled port: fifth pixel dropped, head held; VSYNC ignored during flush.
    wr_ready = 1'b0;
    startFrame();
    startLine(); sendPixels(H, 0); endLine(0);
    startLine(); sendPixels(1, 0);
    applyStimulus();
    checkOutput("ovf_flag", overflow, 1);
    checkOutput("ovf_head_addr", wr_addr, 0);
    endLine(0);
    startFrame(); applyStimulus();
    checkOutput("flush_ignores_vsync", busy, 1);
    wr_ready = 1'b1;
    waitDrained(100);

    // Restart while waiting for a line.
    startFrame();
    startLine(); sendPixels(2, 0); endLine(0);
    startFrame();
    checkOutput("restart_start", frame_start, 1);
    checkOutput("restart_line_cnt", line_cnt, 0);
    for (int l = 0; l < V; l++) begin startLine(); sendPixels(H, 1); endLine(0); end
    waitDrained(100);

    // Reset mid-line with entries queued, then VSYNC held high across release.
    startFrame();
    startLine(); sendPixels(H, 0); endLine(0);
    wr_ready = 1'b0;
    startLine(); sendPixels(2, 0);
    reset_n = 1'b0;
    #1;
    checkOutput("rst_mid_wr_en", wr_en, 0);
    checkOutput("rst_mid_line_cnt", line_cnt, 0);
    checkOutput("rst_mid_overflow", overflow, 0);
    checkOutput("rst_mid_busy", busy, 0);
    applyStimulus();
    wr_ready = 1'b1;
    reset_n = 1'b1;
    repeat (5) applyStimulus();
    checkOutput("no_start_on_held_vsync", busy, 0);
    startFrame();
    checkOutput("start_after_revsync", frame_start, 1);
    for (int l = 0; l < V; l++) begin startLine(); sendPixels(H, 0); endLine(0); end
    waitDrained(100);

    // Random frames with random back-pressure, gaps and line lengths.
    randReady = 1;
    for (int f = 0; f < 20; f++) begin
      startFrame();
      for (int l = 0; l < V; l++) begin
        int n = $urandom_range(0, H + 2);
        bit joint = ($urandom_range(0, 2) == 0) && n > 0;
        startLine();
        sendPixels(joint ? n - 1 : n, 1);
        endLine(joint);
      end
      waitDrained(300);
    end
    randReady = 0;
    wr_ready = 1'b1;
    repeat (3) applyStimulus();

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/mipi_frame_writer.md
MIPI_FRAME_WRITER -- requirements
Module: mipi_frame_writer

Interface
REQ-001 Parameter H_PIXELS, default 960, pixels (16-bit words) per active line.
REQ-002 Parameter V_LINES, default 540, active lines per frame.
REQ-003 Parameter ADDR_W, default 20, frame-buffer word-address width; H_PIXELS*V_LINES SHALL be at most 2^ADDR_W.
REQ-004 Parameter FIFO_DEPTH, default 4, write-buffer entries; SHALL be a power of two.
REQ-005 CAM_CLK  in  1  sole clock; all state changes on its rising edge.
REQ-006 RESET_N  in  1  asynchronous, active-low reset.
REQ-007 VSYNC  in  1  level; high while the upstream deserializer sits in frame-sync-detected state.
REQ-008 HSYNC  in  1  level; high while upstream sits in line-sync-detected state.
REQ-009 PIX_VALID  in  1  one-cycle strobe; PIX_DATA is valid in the same cycle.
REQ-010 PIX_DATA  in  16  RGB565 pixel word.
REQ-011 LINE_END  in  1  level; high once upstream has finished the current line.
REQ-012 WR_READY  in  1  frame-buffer port accepts a write this cycle.
REQ-013 WR_EN  out  1  write request; high whenever the FIFO is non-empty.
REQ-014 WR_ADDR  out  ADDR_W  word address of the FIFO head entry.
REQ-015 WR_DATA  out  16  pixel word of the FIFO head entry.
REQ-016 FRAME_START  out  1  one-cycle pulse on frame acceptance.
REQ-017 FRAME_DONE  out  1  one-cycle pulse after the last pixel of a frame has been written.
REQ-018 LINE_CNT  out  10  index of the current line.
REQ-019 OVERFLOW  out  1  sticky; a pixel was dropped because the FIFO was full.
REQ-020 BUSY  out  1  high in every state except IDLE.

Function
REQ-021 Registered copies of VSYNC, HSYNC and LINE_END SHALL be used for rising-edge detection (signal=1, previous sample=0).
REQ-022 The FSM SHALL have the states IDLE, WAIT_LINE, ACTIVE and FLUSH.
REQ-023 IDLE: on a VSYNC rise, go to WAIT_LINE, clear LINE_CNT, pixel counter and line base address, and pulse FRAME_START.
REQ-024 WAIT_LINE: on an HSYNC rise, go to ACTIVE and clear the pixel counter; a VSYNC rise here SHALL restart the frame as in REQ-023 (the partial frame is abandoned, FIFO contents still drain).
REQ-025 ACTIVE: each PIX_VALID with pixel counter < H_PIXELS SHALL push {base+pixcnt, PIX_DATA} and increment the pixel counter; PIX_VALID at counter = H_PIXELS SHALL be ignored with no flag.
REQ-026 ACTIVE: on a LINE_END rise, increment LINE_CNT and add H_PIXELS to the base; go to FLUSH if the new LINE_CNT = V_LINES, otherwise to WAIT_LINE; short lines are not padded.
REQ-027 If PIX_VALID and a LINE_END rise occur in the same cycle, the pixel SHALL be pushed first, using the old line address.
REQ-028 FLUSH: when the FIFO is empty, pulse FRAME_DONE and go to IDLE; VSYNC is ignored in FLUSH.
REQ-029 The address SHALL be formed from a running base register plus the pixel counter, with no multiplier.
REQ-030 The FIFO SHALL be first-word-fall-through; WR_ADDR and WR_DATA SHALL be held stable while WR_EN=1 and WR_READY=0.
REQ-031 A pop SHALL occur when WR_EN=1 and WR_READY=1; a push and a pop in the same cycle SHALL both occur, including when the FIFO is full.
REQ-032 A push into a full FIFO with no simultaneous pop SHALL drop the pixel and set OVERFLOW.
REQ-033 Latency: with the FIFO empty, a pixel strobed in cycle t SHALL appear on WR_EN/WR_ADDR/WR_DATA in cycle t+1.

Reset
REQ-034 Asserting RESET_N=0, at any time including mid-frame, SHALL immediately force the FSM to IDLE, empty the FIFO, and drive every output to 0 (WR_EN, WR_ADDR, WR_DATA, FRAME_START, FRAME_DONE, LINE_CNT, OVERFLOW, BUSY).
REQ-035 After RESET_N=1, the block SHALL ignore VSYNC that is already high until it falls and rises again.

Verification
REQ-036 Drive VSYNC, HSYNC, 960 strobes of PIX_DATA=0x1000+i, then LINE_END, with WR_READY=1 -> writes at addresses 0..959 with matching data; LINE_CNT=1.
REQ-037 Run a full frame with H_PIXELS=4, V_LINES=2 -> 8 writes at addresses 0..7, FRAME_DONE one cycle after the last write, BUSY=0 the cycle after.
REQ-038 Hold WR_READY=0 and strobe 5 pixels -> 4 entries held, OVERFLOW=1, WR_ADDR stable at 0; release WR_READY -> addresses 0..3 drain.
REQ-039 Strobe PIX_VALID in the same cycle as a LINE_END rise on line 0 (H_PIXELS=4, 3 pixels prior) -> the pixel is written at address 3 and the next line starts at base 4.
REQ-040 Pull RESET_N low mid-line with 2 entries queued -> WR_EN=0, LINE_CNT=0 and OVERFLOW=0 immediately; after release, with VSYNC held high, FRAME_START does not pulse until VSYNC is re-asserted.
